// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a small FIFO and issues them one at a time over
// the ALU ready/valid/done handshake. Optional watchdog: `define ALU_CMD_ISSUER_TIMEOUT_EN.
`timescale 1ns/1ps
module alu_cmd_issuer #(
    parameter int ALU_IN_OP_WIDTH = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_op,
    input  logic [ALU_IN_OP_WIDTH-1:0]   cmd_a,
    input  logic [ALU_IN_OP_WIDTH-1:0]   cmd_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [2:0]                   rsp_op,
    output logic [2*ALU_IN_OP_WIDTH-1:0] rsp_result,
    output logic                         rsp_timeout,
    input  logic                         alu_ready,
    output logic                         alu_valid,
    output logic [2:0]                   alu_op,
    output logic [ALU_IN_OP_WIDTH-1:0]   alu_a,
    output logic [ALU_IN_OP_WIDTH-1:0]   alu_b,
    output logic                         alu_rst,
    input  logic                         alu_done,
    input  logic [2*ALU_IN_OP_WIDTH-1:0] alu_result
);
    // state     | meaning
    // IDLE      | pop the FIFO head and decode its opcode
    // ISSUE     | wait for alu_ready, strobe alu_valid for one cycle
    // WAIT_DONE | wait for alu_done (or the watchdog)
    // RSTP      | drive alu_rst low for one cycle
    // RESP      | present the response until rsp_ready
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_DONE = 3'd2;
    localparam logic [2:0] RSTP      = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_RST = 3'd7;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int W  = ALU_IN_OP_WIDTH;

    logic [2:0]   fifo_op [FIFO_DEPTH];
    logic [W-1:0] fifo_a  [FIFO_DEPTH];
    logic [W-1:0] fifo_b  [FIFO_DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         full, empty, push, pop;

    logic [2:0]   state;
    logic [2:0]   iss_op;
    logic [W-1:0] iss_a, iss_b;
    logic [2:0]   head_op;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = rst && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !empty;
    assign head_op   = fifo_op[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr[AW-1:0]] <= cmd_op;
            fifo_a[wr_ptr[AW-1:0]]  <= cmd_a;
            fifo_b[wr_ptr[AW-1:0]]  <= cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt;
    logic          rsp_timeout_q;

    // Loaded on the issue cycle so it reaches zero on the last allowed WAIT_DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state == ISSUE && alu_ready) begin
            wd_cnt <= TW'(TIMEOUT_CYCLES - 1);
        end else if (state == WAIT_DONE && wd_cnt != '0) begin
            wd_cnt <= wd_cnt - 1'b1;
        end
    end
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            iss_op     <= '0;
            iss_a      <= '0;
            iss_b      <= '0;
            rsp_op     <= '0;
            rsp_result <= '0;
`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        iss_op <= head_op;
                        iss_a  <= fifo_a[rd_ptr[AW-1:0]];
                        iss_b  <= fifo_b[rd_ptr[AW-1:0]];
                        case (head_op)
                            OP_RST:                         state <= RSTP;
                            OP_ADD, OP_AND, OP_XOR, OP_MUL: state <= ISSUE;
                            default:                        state <= IDLE;
                        endcase
                    end
                end
                RSTP: state <= IDLE;
                ISSUE: begin
                    if (alu_ready) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (alu_done) begin
                        rsp_result <= alu_result;
                        rsp_op     <= iss_op;
`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                        state      <= RESP;
                    end
`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
                    else if (wd_cnt == '0) begin
                        rsp_result    <= '0;
                        rsp_op        <= iss_op;
                        rsp_timeout_q <= 1'b1;
                        state         <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign alu_valid = (state == ISSUE) && alu_ready;
    assign alu_op    = alu_valid ? iss_op : 3'd0;
    assign alu_a     = alu_valid ? iss_a : '0;
    assign alu_b     = alu_valid ? iss_b : '0;
    assign alu_rst   = rst && (state != RSTP);

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Hardware initiator for the ALU's `alu_in`/`alu_out` protocol, i.e. the transmit side of the interface the ALU receives on. Accepts operation commands on a valid/ready stream and buffers them in a small FIFO. Issues them one at a time to the ALU using its ready/valid/done handshake, then returns each result on a valid/ready response stream. Sits between an on-chip command source (CPU bridge or test sequencer) and the ALU.

## Interface

Parameters:
- `ALU_IN_OP_WIDTH`, 8: operand width; result width is 2×`ALU_IN_OP_WIDTH`.
- `FIFO_DEPTH`, 4: command FIFO entries; must be a power of two ≥ 2.
- `TIMEOUT_CYCLES`, 64: watchdog limit in `WAIT_DONE`; only used when the watchdog is compiled in.

Ports:
- `clk` in 1: sole clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_op` in 3: opcode (0 no_op, 1 add, 2 and, 3 xor, 4 mul, 7 rst_op; 5 and 6 reserved).
- `cmd_a`, `cmd_b` in `ALU_IN_OP_WIDTH`: operands.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_op` out 3: opcode of the returned result.
- `rsp_result` out 2×`ALU_IN_OP_WIDTH`: ALU result.
- `rsp_timeout` out 1: response was produced by the watchdog, not by `alu_done`.
- `alu_ready` in 1: ALU can accept an operation.
- `alu_valid` out 1: one-cycle issue strobe.
- `alu_op` out 3, `alu_a`/`alu_b` out `ALU_IN_OP_WIDTH`: issued operation.
- `alu_rst` out 1: ALU reset, active-low.
- `alu_done` in 1, `alu_result` in 2×`ALU_IN_OP_WIDTH`: ALU completion and result.

## Operation

- **Command FIFO.**
  - `cmd_ready` = FIFO not full. A push occurs on `cmd_valid && cmd_ready`.
  - Pointers are log2(`FIFO_DEPTH`)+1 bits with wrap bit; full and empty are decoded from the wrap bit.
  - No bypass: a pushed entry is visible to the FSM the cycle after the push.
  - Push and pop in the same cycle are legal when not full. When full, no push is accepted, even if a pop occurs that cycle.
- **FSM states:** `IDLE`, `ISSUE`, `WAIT_DONE`, `RSTP`, `RESP`.
- **IDLE.** If the FIFO is non-empty, pop the head into the issue register and go to the next state by opcode:
  - no_op and reserved opcodes (5, 6): discarded; stay in `IDLE`; no response.
  - rst_op: go to `RSTP`.
  - otherwise: go to `ISSUE`.
- **RSTP.**
  - `alu_rst`=0 for exactly one cycle, then return to `IDLE`.
  - No response is produced.
- **ISSUE.**
  - Wait for `alu_ready`=1.
  - In the cycle `alu_ready`=1: `alu_valid`=1 with `alu_op`/`alu_a`/`alu_b` from the issue register; next state `WAIT_DONE`.
  - `alu_valid` is never high for more than one consecutive cycle.
- **WAIT_DONE.**
  - On `alu_done`=1: capture `alu_result` into `rsp_result`, set `rsp_op` from the issue register, set `rsp_timeout`=0; go to `RESP`.
  - `alu_done` is sampled only in `WAIT_DONE`. It is ignored in every other state, including the `alu_valid` cycle itself.
- **RESP.**
  - `rsp_valid`=1 and all response outputs are held stable until `rsp_ready`=1.
  - Then go to `IDLE`; `rsp_valid` is low the following cycle.
- **ALU-side outputs** (`alu_op`, `alu_a`, `alu_b`) are 0 whenever `alu_valid`=0.

## Timing

- **Reset** (`rst`=0 sampled at a clock edge):
  - FIFO emptied, FSM to `IDLE`, watchdog counter cleared.
  - `cmd_ready`=0, `rsp_valid`=0, `rsp_op`=0, `rsp_result`=0, `rsp_timeout`=0, `alu_valid`=0, `alu_op`/`alu_a`/`alu_b`=0.
  - `alu_rst`=0 while `rst`=0, so reset propagates to the ALU.
  - Reset mid-operation abandons the in-flight command and its response.
  - The first cycle after reset release: `cmd_ready`=1, `alu_rst`=1.
- **Minimum latency:**
  - Command accepted at cycle N → popped at N+1 → `alu_valid` at N+2 (if `alu_ready`=1).
  - `alu_done` at cycle M → `rsp_valid` at M+1.
- **Throughput:** at most one ALU operation in flight.
- **Back-pressure:** `rsp_ready` held low blocks the FSM in `RESP`. The FIFO continues to accept commands until full.

## Configuration

- **`ALU_CMD_ISSUER_TIMEOUT_EN` defined:**
  - A counter runs in `WAIT_DONE`.
  - After `TIMEOUT_CYCLES` cycles without `alu_done`, the FSM goes to `RESP` with `rsp_result`=0 and `rsp_timeout`=1.
  - If `alu_done` arrives in the same cycle the limit is reached, `alu_done` wins and `rsp_timeout`=0.
- **Not defined:**
  - `WAIT_DONE` waits indefinitely.
  - `rsp_timeout` is constant 0.
  - No counter logic is present.

## Test plan

- add, a=8'h0F, b=8'h01, `alu_ready`=1, `alu_done` 3 cycles after `alu_valid` with result 16'h0010 → exactly one `alu_valid` pulse at N+2. Response: `rsp_op`=1, `rsp_result`=16'h0010, `rsp_timeout`=0.
- Push 5 commands back-to-back with `alu_ready`=0 and `FIFO_DEPTH`=4 → FSM pops 1 into the issue register, FIFO holds 4, and `cmd_ready` drops once full. After releasing `alu_ready`, all 5 results return in order.
- rst_op followed by xor a=8'hAA, b=8'h55 → `alu_rst` low for one cycle and no response for rst_op. Then one response: `rsp_op`=3, `rsp_result` equal to `alu_result` (16'h00FF).
- no_op and opcode 6 → no `alu_valid` and no response. `alu_done` pulsed in `IDLE` → ignored.
- `rsp_ready`=0 for 10 cycles during `RESP` → `rsp_valid`, `rsp_op`, `rsp_result` stable all 10 cycles; single completion when `rsp_ready`=1.
- `rst`=0 for one cycle in `WAIT_DONE` with 2 queued commands → all outputs at reset values and FIFO empty; no responses afterwards. With `ALU_CMD_ISSUER_TIMEOUT_EN` defined and no `alu_done` → response after 64 cycles with `rsp_timeout`=1, `rsp_result`=0.
